// File: rtl/secuenciador_interrupcion.sv
// secuenciador_interrupcion: CPU-side interrupt sequencer.
// Watches the controller's pending/in-service vectors, decides when to take
// an interrupt, strobes s_calli/s_reti back, redirects the PC and keeps a
// return-address stack so interrupts can nest.
// Optional feature: define INT_MASK_EN to add a software-writable line mask.
module secuenciador_interrupcion #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PCW   = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_int_s,
    input  logic [WIDTH-1:0] i_int_a,
    input  logic             i_ei,
    input  logic             i_di,
    input  logic             i_reti_op,
    input  logic [PCW-1:0]   i_pc_actual,
    input  logic             i_mask_we,
    input  logic [WIDTH-1:0] i_mask_in,
    output logic [WIDTH-1:0] o_s_calli,
    output logic [WIDTH-1:0] o_s_reti,
    output logic             o_pc_sel,
    output logic [PCW-1:0]   o_pc_out,
    output logic             o_stall,
    output logic             o_err_pila
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PCW-1:0] VEC_BASE = PCW'(10'h200);
    localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_CALL, ST_RET} state_t;

    state_t           r_state, w_next;
    logic             r_ie;
    logic [SPW-1:0]   r_sp;
    logic             r_err;
    logic [WIDTH-1:0] r_k_oh;
    logic [WIDTH-1:0] r_j_oh;
    logic [PCW-1:0]   r_vec;
    logic [PCW-1:0]   r_stack [DEPTH];

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_cand;
    logic [WIDTH-1:0] w_cand_oh;
    logic [WIDTH-1:0] w_act_oh;
    logic [KW-1:0]    w_cand_idx;
    logic             w_take;
    logic [IW-1:0]    w_top_idx;
    logic [PCW-1:0]   w_top;
    logic [PCW-1:0]   w_vec;

    // Isolate the highest set bit; zero in gives zero out.
    function automatic logic [WIDTH-1:0] f_hp_oh(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Index of the highest set bit (0 when x is zero; callers gate on x != 0).
    function automatic logic [KW-1:0] f_hp_idx(input logic [WIDTH-1:0] x);
        logic [KW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) r = KW'(i);
        end
        return r;
    endfunction

`ifdef INT_MASK_EN
    logic [WIDTH-1:0] r_mask;

    // Software mask; a write takes effect from the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset)        r_mask <= '1;
        else if (i_mask_we) r_mask <= i_mask_in;
    end

    assign w_mask = r_mask;
`else
    logic w_unused_mask;
    assign w_mask        = '1;
    assign w_unused_mask = ^{i_mask_we, i_mask_in};
`endif

    // Comparing the one-hot highest bits as unsigned numbers is the same as
    // hp(cand) > hp(int_a) with hp(0) = -1, and it implies cand != 0.
    assign w_cand     = i_int_s & ~i_int_a & w_mask;
    assign w_cand_oh  = f_hp_oh(w_cand);
    assign w_act_oh   = f_hp_oh(i_int_a);
    assign w_cand_idx = f_hp_idx(w_cand);
    assign w_take     = r_ie && (w_cand_oh > w_act_oh) && (r_sp < SP_FULL) && !i_reti_op;
    assign w_vec      = VEC_BASE + PCW'(WIDTH - 1) - PCW'(w_cand_idx);
    assign w_top_idx  = IW'(r_sp - SPW'(1));
    assign w_top      = r_stack[w_top_idx];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        w_next    = r_state;
        o_s_calli = '0;
        o_s_reti  = '0;
        o_pc_sel  = 1'b0;
        o_pc_out  = '0;
        o_stall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_reti_op)   w_next = ST_RET;
                else if (w_take) w_next = ST_CALL;
            end
            ST_CALL: begin
                o_s_calli = r_k_oh;
                o_pc_sel  = 1'b1;
                o_pc_out  = r_vec;
                o_stall   = 1'b1;
                w_next    = ST_IDLE;
            end
            ST_RET: begin
                if (r_sp != '0) begin
                    o_s_reti = r_j_oh;
                    o_pc_sel = 1'b1;
                    o_pc_out = w_top;
                    o_stall  = 1'b1;
                end
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Enable flag, latched call/return targets, stack pointer and error flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ie   <= 1'b0;
            r_sp   <= '0;
            r_err  <= 1'b0;
            r_k_oh <= '0;
            r_j_oh <= '0;
            r_vec  <= '0;
        end else begin
            if (i_di)      r_ie <= 1'b0;
            else if (i_ei) r_ie <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (i_reti_op) begin
                        r_j_oh <= w_act_oh;
                    end else if (w_take) begin
                        r_k_oh <= w_cand_oh;
                        r_vec  <= w_vec;
                    end
                end
                ST_CALL: begin
                    if (r_sp == SP_FULL) r_err <= 1'b1;
                    else                 r_sp  <= r_sp + SPW'(1);
                end
                ST_RET: begin
                    if (r_sp == '0) r_err <= 1'b1;
                    else            r_sp  <= r_sp - SPW'(1);
                end
                default: ;
            endcase
        end
    end

    // Return-address storage; a reset in the CALL cycle drops the push.
    always_ff @(posedge i_clk) begin
        if (!i_reset && r_state == ST_CALL && r_sp < SP_FULL)
            r_stack[r_sp[IW-1:0]] <= i_pc_actual;
    end

    assign o_err_pila = r_err;

endmodule
